shared_unit_arbiter: RTL and testbench
======================================

SHARED_UNIT_ARBITER -- requirements
Module: shared_unit_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 8, max WAIT cycles before abandoning an operation (legal range 1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  synchronous, active-low reset.
REQ-004 Port: req0 / req1  in  1 each  requester operation request.
REQ-005 Port: op0 / op1  in  5 each  operand bundle {A[1:0],B,C,D} of the requester.
REQ-006 Port: ack0 / ack1  out  1 each  one-cycle completion pulse to requester.
REQ-007 Port: q0 / q1  out  1 each  result to requester; valid only while its ack is high.
REQ-008 Port: issue  out  1  one-cycle launch strobe to the shared compute unit.
REQ-009 Port: issue_op  out  5  operand bundle to the shared unit, valid while issue=1.
REQ-010 Port: res_valid  in  1  shared-unit result strobe.
REQ-011 Port: res_q  in  1  shared-unit result, sampled when res_valid=1.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: grant_id  out  1  index of current/last granted requester.
REQ-014 Port: timeout  out  1  sticky flag, set when an operation times out.
REQ-015 Port: timeout_clr  in  1  clears timeout flag.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-017 IDLE: no req -> stay; any req -> select requester, latch its op and index, go ISSUE next cycle.
REQ-018 Arbitration: single requester always wins; both requesting -> grant the index != last_grant (round-robin).
REQ-019 last_grant updates only on RESP exit; reset value 1 so req0 wins the first tie.
REQ-020 ISSUE: issue=1 and issue_op=latched op for exactly one cycle; clear wait counter; go WAIT.
REQ-021 WAIT: res_valid=1 -> latch res_q, go RESP; else counter +1.
REQ-022 WAIT: counter reaching TIMEOUT without res_valid -> set timeout, latch result 0, go RESP.
REQ-023 res_valid and timeout condition in same cycle: result wins, timeout not set.
REQ-024 res_valid outside WAIT ignored; no state or output change.
REQ-025 RESP: ack of granted requester =1 one cycle, its q = latched result; other ack/q =0; go IDLE.
REQ-026 Minimum latency: req sampled in IDLE at cycle N -> issue at N+1 -> ack earliest N+3 (res_valid at N+2).
REQ-027 Back-to-back: next grant evaluated in the IDLE cycle after RESP; min 4 cycles per transaction.
REQ-028 Requesters hold req/op stable until ack; req dropped mid-transaction does not abort; ack still pulses.
REQ-029 Ops sampled only in IDLE; op changes after grant do not affect issue_op.
REQ-030 timeout_clr clears timeout the next cycle; set in same cycle as clear -> set wins.
REQ-031 q0/q1 =0 whenever corresponding ack=0.

Reset
REQ-032 rst_n=0 at a clock edge forces IDLE, last_grant=1, grant_id=0, counter=0, timeout=0, latched op/result=0.
REQ-033 During/after reset: issue, ack0, ack1, q0, q1, busy, issue_op all 0.
REQ-034 Reset mid-transaction abandons it: no ack produced; a subsequent res_valid is ignored.

Verification
REQ-035 Single req0, op0=5'b10110, res_valid+res_q=1 one cycle after issue -> issue_op=10110, ack0 & q0=1 at N+3, ack1 never.
REQ-036 req0,req1 both held from reset -> grant order 0,1,0,1 across four transactions; grant_id matches each ack.
REQ-037 TIMEOUT=8, res_valid never asserted -> ack with q=0 after 8 WAIT cycles, timeout=1 sticky until timeout_clr pulse.
REQ-038 res_valid asserted on the cycle counter hits TIMEOUT with res_q=1 -> q=1, timeout stays 0.
REQ-039 rst_n low during WAIT, then res_valid pulse -> no ack, FSM IDLE, busy=0; next req serviced normally with req0 priority.
REQ-040 Spurious res_valid in IDLE and RESP -> no ack, no state change, outputs unchanged.

Source files
------------

// File: rtl/shared_unit_arbiter.sv
// Two-requester arbiter in front of a single shared compute unit.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Ties between requesters are broken round-robin on the last completed grant.
// An operation abandoned after TIMEOUT wait cycles completes with result 0
// and raises a sticky timeout flag.
module shared_unit_arbiter #(
  parameter int unsigned TIMEOUT = 8  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [4:0] op0,
  input  logic [4:0] op1,
  output logic       ack0,
  output logic       ack1,
  output logic       q0,
  output logic       q1,
  output logic       issue,
  output logic [4:0] issue_op,
  input  logic       res_valid,
  input  logic       res_q,
  output logic       busy,
  output logic       grant_id,
  output logic       timeout,
  input  logic       timeout_clr
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Value of the wait counter during the last permitted WAIT cycle.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [4:0] op_q, op_d;
  logic       rslt_q, rslt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic       pick;
  logic       timeout_set;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last_q;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  // Next-state logic for the transaction FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    op_d        = op_q;
    rslt_d      = rslt_q;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Operands are captured only here; later op changes are invisible.
        if (req0 || req1) begin
          grant_d = pick;
          op_d    = pick ? op1 : op0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A result arriving in the final wait cycle beats the timeout.
        if (res_valid) begin
          rslt_d  = res_q;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          timeout_set = 1'b1;
          rslt_d      = 1'b0;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Setting wins over a simultaneous clear.
    timeout_d = timeout_set | (timeout_q & ~timeout_clr);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      op_q      <= '0;
      rslt_q    <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      op_q      <= op_d;
      rslt_q    <= rslt_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    issue    = (state_q == StIssue);
    issue_op = issue ? op_q : 5'd0;
    ack0     = (state_q == StResp) && !grant_q;
    ack1     = (state_q == StResp) && grant_q;
    q0       = ack0 & rslt_q;
    q1       = ack1 & rslt_q;
    busy     = (state_q != StIdle);
    grant_id = grant_q;
    timeout  = timeout_q;
  end

  // Protocol sanity checks.
  ack_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) !(ack0 && ack1));
  issue_pulse_a: assert property (@(posedge clk) disable iff (!rst_n) issue |=> !issue);
  q_gated_a: assert property (@(posedge clk) disable iff (!rst_n) (!q0 || ack0) && (!q1 || ack1));

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Randomized scoreboard bench for shared_unit_arbiter. The driver computes each
// transaction's expected winner, issue operand, result, timeout flag and cycle
// of completion from the arbitration rules, a shared-unit responder model
// returns results with a planned delay, and a monitor checks every issue/ack.
module tb_shared_unit_arbiter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [4:0] op0, op1;
  logic       ack0, ack1, q0, q1;
  logic       issue;
  logic [4:0] issue_op;
  logic       res_valid, res_q;
  logic       busy, grant_id, timeout;
  logic       timeout_clr;

  shared_unit_arbiter #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .op0        (op0),
    .op1        (op1),
    .ack0       (ack0),
    .ack1       (ack1),
    .q0         (q0),
    .q1         (q1),
    .issue      (issue),
    .issue_op   (issue_op),
    .res_valid  (res_valid),
    .res_q      (res_q),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout    (timeout),
    .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic id;
    logic q;
    logic to;
    int   cyc;
  } ack_t;
  typedef struct {
    logic [4:0] op;
    int         cyc;
  } iss_t;
  typedef struct {
    int   d;     // WAIT cycle (1-based) carrying the result; > T means never
    logic r;
    int   spur;  // 0 none, 1 spurious pulse in RESP, 2 spurious pulse in the following IDLE
  } plan_t;

  ack_t  exp_ack[$];
  iss_t  exp_iss[$];
  plan_t plan[$];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic       pend[2];
  logic [4:0] opv[2];
  logic       last;
  logic       sticky;
  bit         abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an issue or ack.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        chk("ack_expected", 32'(exp_ack.size() > 0), 32'(1));
        if (exp_ack.size() > 0) begin
          ack_t a;
          a = exp_ack.pop_front();
          chk("ack_onehot", 32'({ack0, ack1}), a.id ? 32'(2'b01) : 32'(2'b10));
          chk("ack_q", 32'(a.id ? q1 : q0), 32'(a.q));
          chk("other_q", 32'(a.id ? q0 : q1), 32'(0));
          chk("grant_id", 32'(grant_id), 32'(a.id));
          chk("timeout_flag", 32'(timeout), 32'(a.to));
          chk("ack_cycle", cyc, a.cyc);
        end
      end
      if (ack0 == 1'b0) chk("q0_gated", 32'(q0), 32'(0));
      if (ack1 == 1'b0) chk("q1_gated", 32'(q1), 32'(0));
      if (issue === 1'b1) begin
        chk("issue_expected", 32'(exp_iss.size() > 0), 32'(1));
        if (exp_iss.size() > 0) begin
          iss_t s;
          s = exp_iss.pop_front();
          chk("issue_op", 32'(issue_op), 32'(s.op));
          chk("issue_cycle", cyc, s.cyc);
        end
      end
    end
  end

  // Shared-unit model: answers each issue according to the next plan entry.
  initial begin
    res_valid = 1'b0;
    res_q     = 1'b0;
    forever begin
      @(negedge clk);
      if (issue === 1'b1 && plan.size() > 0) begin
        plan_t p;
        int    k;
        p = plan.pop_front();
        k = (p.d <= T) ? p.d : T;
        for (int j = 1; j <= k + p.spur; j++) begin
          @(posedge clk);
          #1;
          if (j == p.d && p.d <= T) begin
            res_valid = 1'b1;
            res_q     = p.r;
          end else if (p.spur != 0 && j == k + p.spur) begin
            res_valid = 1'b1;
            res_q     = 1'b1;
          end else begin
            res_valid = 1'b0;
            res_q     = 1'($urandom);
          end
        end
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        res_q     = 1'b0;
      end
    end
  end

  // One transaction, started in an IDLE cycle. Requesters not already pending
  // may raise a new request; the model decides the winner and its outcome.
  task automatic do_txn(input logic w0, input logic w1, input logic [4:0] n0,
                        input logic [4:0] n1, input int d, input logic r, input int spur,
                        input int clr_mode, input bit mid);
    logic  w, timed, q_e, to_e;
    int    k;
    bit    got;
    ack_t  a;
    iss_t  s;
    plan_t p;
    if (abort) return;
    if (!pend[0] && w0) begin pend[0] = 1'b1; opv[0] = n0; end
    if (!pend[1] && w1) begin pend[1] = 1'b1; opv[1] = n1; end
    if (!pend[0] && !pend[1]) begin pend[0] = 1'b1; opv[0] = n0; end
    w     = (pend[0] && pend[1]) ? ~last : (pend[0] ? 1'b0 : 1'b1);
    timed = (d > T);
    k     = timed ? T : d;
    q_e   = timed ? 1'b0 : r;
    to_e  = (clr_mode == 0) ? (sticky | timed) : timed;

    req0        = pend[0];
    req1        = pend[1];
    op0         = pend[0] ? opv[0] : 5'($urandom);
    op1         = pend[1] ? opv[1] : 5'($urandom);
    timeout_clr = (clr_mode == 1);
    p = '{d, r, spur};
    s = '{opv[w], cyc + 1};
    a = '{w, q_e, to_e, cyc + 2 + k};
    plan.push_back(p);
    exp_iss.push_back(s);
    exp_ack.push_back(a);

    @(posedge clk);
    #1;
    timeout_clr = (clr_mode == 2);
    // Winner withdraws and scribbles its operands after the grant.
    if (mid) begin
      if (w) begin req1 = 1'b0; op1 = ~opv[1]; end
      else   begin req0 = 1'b0; op0 = ~opv[0]; end
    end

    got = 1'b0;
    for (int i = 0; i < T + 12 && !got; i++) begin
      @(negedge clk);
      got = (ack0 === 1'b1) || (ack1 === 1'b1);
    end
    chk("ack_seen", 32'(got), 32'(1));
    if (!got) begin
      abort = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    timeout_clr = 1'b0;
    pend[w]     = 1'b0;
    last        = w;
    sticky      = (clr_mode == 2) ? 1'b0 : to_e;
    if (w) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    req0        = 1'b1;
    req1        = 1'b1;
    op0         = 5'h1f;
    op1         = 5'h15;
    timeout_clr = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    opv[0]  = '0;   opv[1]  = '0;
    last    = 1'b1;
    sticky  = 1'b0;

    // Reset holds everything quiet even with requests present.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_issue", 32'(issue), 32'(0));
    chk("rst_issue_op", 32'(issue_op), 32'(0));
    chk("rst_ack0", 32'(ack0), 32'(0));
    chk("rst_ack1", 32'(ack1), 32'(0));
    chk("rst_q0", 32'(q0), 32'(0));
    chk("rst_q1", 32'(q1), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    @(posedge clk);
    #1;

    // Single req0, result one cycle after issue: ack0 with q0=1 at N+3.
    do_txn(1'b1, 1'b0, 5'b10110, 5'd0, 1, 1'b1, 0, 0, 1'b0);
    // Both requesting: grants alternate 0,1,0,1.
    do_txn(1'b1, 1'b1, 5'h03, 5'h1c, 2, 1'b1, 0, 0, 1'b0);
    do_txn(1'b1, 1'b1, 5'h07, 5'h11, 1, 1'b0, 0, 0, 1'b0);
    do_txn(1'b1, 1'b1, 5'h0a, 5'h12, 3, 1'b1, 0, 0, 1'b0);
    do_txn(1'b1, 1'b1, 5'h0b, 5'h13, 1, 1'b1, 0, 0, 1'b0);
    // No result: timeout after T wait cycles, flag sticky, then cleared.
    do_txn(1'b0, 1'b0, 5'h01, 5'h02, T + 1, 1'b1, 0, 0, 1'b0);
    do_txn(1'b0, 1'b1, 5'h04, 5'h05, 2, 1'b1, 0, 0, 1'b0);
    do_txn(1'b1, 1'b0, 5'h06, 5'h08, 2, 1'b1, 0, 1, 1'b0);
    // Result on the last permitted wait cycle beats the timeout.
    do_txn(1'b1, 1'b0, 5'h09, 5'h0c, T, 1'b1, 0, 0, 1'b0);
    // Spurious results in RESP and IDLE are ignored.
    do_txn(1'b0, 1'b1, 5'h0d, 5'h0e, 1, 1'b1, 1, 0, 1'b0);
    do_txn(1'b1, 1'b0, 5'h0f, 5'h10, 4, 1'b0, 2, 0, 1'b0);
    // Timeout set while clear is held: set wins, clear takes effect afterwards.
    do_txn(1'b1, 1'b1, 5'h14, 5'h16, T + 1, 1'b1, 0, 2, 1'b0);
    // Requester drops and changes op after the grant.
    do_txn(1'b1, 1'b1, 5'h17, 5'h18, 2, 1'b1, 0, 0, 1'b1);

    for (int n = 0; n < 200 && !abort; n++) begin
      int cm;
      if (!pend[0] && !pend[1] && $urandom_range(0, 3) == 0) begin
        req0 = 1'b0;
        req1 = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      cm = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 7) == 0) ? 2 : 0);
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
             $urandom_range(1, T + 1), 1'($urandom), ($urandom_range(0, 2) == 0) ? 0 :
             $urandom_range(1, 2), cm, $urandom_range(0, 3) == 0);
    end

    // Drain any request still pending before the reset scenario.
    while ((pend[0] || pend[1]) && !abort)
      do_txn(1'b0, 1'b0, 5'($urandom), 5'($urandom), 1, 1'b1, 0, 0, 1'b0);

    // Reset during WAIT: no ack, late result ignored, tie then goes to req0.
    if (!abort) begin
      plan_t p;
      iss_t  s;
      req0 = 1'b0;
      req1 = 1'b1;
      op1  = 5'h0d;
      p = '{3, 1'b1, 0};
      s = '{5'h0d, cyc + 1};
      plan.push_back(p);
      exp_iss.push_back(s);
      @(posedge clk);
      #1;
      req1 = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("busy_after_reset", 32'(busy), 32'(0));
        chk("grant_after_reset", 32'(grant_id), 32'(0));
      end
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      last    = 1'b1;
      sticky  = 1'b0;
      do_txn(1'b1, 1'b1, 5'h11, 5'h0e, 2, 1'b1, 0, 0, 1'b0);
      do_txn(1'b0, 1'b0, 5'h00, 5'h00, 1, 1'b0, 0, 0, 1'b0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ack_queue_empty", exp_ack.size(), 0);
    chk("issue_queue_empty", exp_iss.size(), 0);
    chk("final_busy", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
